// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, 32 iterations each, plus single-cycle MTHI/MTLO writes.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_execute,
    input  logic [2:0]  mult_div_op_execute,
    input  logic [31:0] src_A_ALU_execute,
    input  logic [31:0] src_B_ALU_execute,
    input  logic        flush_execute,
    output logic [31:0] HI_output,
    output logic [31:0] LO_output,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] operand;
    logic        neg_q;
    logic        neg_r;

    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_result;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_sub;
    logic [31:0] div_rem_next;
    logic [31:0] div_quo_next;

    // In DIV the accumulator holds {partial remainder, dividend/quotient shifter}.
    always_comb begin
        signed_op    = (mult_div_op_execute == OP_MULT) || (mult_div_op_execute == OP_DIV);
        mag_a        = (signed_op && src_A_ALU_execute[31]) ? (~src_A_ALU_execute + 32'd1)
                                                            : src_A_ALU_execute;
        mag_b        = (signed_op && src_B_ALU_execute[31]) ? (~src_B_ALU_execute + 32'd1)
                                                            : src_B_ALU_execute;

        mul_sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        mul_next     = {mul_sum, acc[31:1]};
        mul_result   = neg_q ? (~mul_next + 64'd1) : mul_next;

        div_shift    = {acc[63:32], acc[31]};
        div_ok       = div_shift >= {1'b0, operand};
        div_sub      = div_shift[31:0] - operand;
        div_rem_next = div_ok ? div_sub : div_shift[31:0];
        div_quo_next = {acc[30:0], div_ok};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= 5'd0;
            acc       <= 64'd0;
            operand   <= 32'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            HI_output <= 32'd0;
            LO_output <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (flush_execute) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_execute) begin
                        case (mult_div_op_execute)
                            OP_MULT, OP_MULTU: begin
                                acc     <= {32'd0, mag_b};
                                operand <= mag_a;
                                neg_q   <= signed_op && (src_A_ALU_execute[31] ^ src_B_ALU_execute[31]);
                                neg_r   <= signed_op && src_A_ALU_execute[31];
                                count   <= 5'd0;
                                state   <= MUL;
                                busy    <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {32'd0, mag_a};
                                operand <= mag_b;
                                neg_q   <= signed_op && (src_A_ALU_execute[31] ^ src_B_ALU_execute[31]);
                                neg_r   <= signed_op && src_A_ALU_execute[31];
                                count   <= 5'd0;
                                state   <= DIV;
                                busy    <= 1'b1;
                            end
                            OP_MTHI: HI_output <= src_A_ALU_execute;
                            OP_MTLO: LO_output <= src_A_ALU_execute;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        HI_output <= mul_result[63:32];
                        LO_output <= mul_result[31:0];
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DIV: begin
                    acc   <= {div_rem_next, div_quo_next};
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        LO_output <= neg_q ? (~div_quo_next + 32'd1) : div_quo_next;
                        HI_output <= neg_r ? (~div_rem_next + 32'd1) : div_rem_next;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pairs are queued at issue
// time and popped when the unit reports done.
module tb_mult_div_unit;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_execute = 1'b0;
    logic [2:0]  mult_div_op_execute = OP_NOP;
    logic [31:0] src_A_ALU_execute = 32'd0;
    logic [31:0] src_B_ALU_execute = 32'd0;
    logic        flush_execute = 1'b0;
    logic [31:0] HI_output;
    logic [31:0] LO_output;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    result_t sb_queue[$];

    mult_div_unit dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start_execute       (start_execute),
        .mult_div_op_execute (mult_div_op_execute),
        .src_A_ALU_execute   (src_A_ALU_execute),
        .src_B_ALU_execute   (src_B_ALU_execute),
        .flush_execute       (flush_execute),
        .HI_output           (HI_output),
        .LO_output           (LO_output),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Reference results computed from wide arithmetic, independent of the iterative datapath.
    function automatic result_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t r;
        logic [63:0] p;
        longint sa, sb, q, rm;
        r = '0;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                r  = {p[63:32], p[31:0]};
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                r = {p[63:32], p[31:0]};
            end
            OP_DIVU: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 0) begin
                    r = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issues an op at the current negedge and waits (bounded) for the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output bit saw_done);
        start_execute       = 1'b1;
        mult_div_op_execute = op;
        src_A_ALU_execute   = a;
        src_B_ALU_execute   = b;
        @(negedge clk);
        start_execute     = 1'b0;
        src_A_ALU_execute = $urandom;
        src_B_ALU_execute = $urandom;
        busy_cnt = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) begin
                busy_cnt++;
                @(negedge clk);
            end else begin
                saw_done = done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({HI_output, LO_output, busy, done} !== 66'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got HI=%h LO=%h busy=%b done=%b, want all zero",
                     HI_output, LO_output, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scoreboard_op(input string name, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input result_t expected);
        int bc;
        bit sd;
        result_t exp_r;
        sb_queue.push_back(expected);
        run_op(op, a, b, bc, sd);
        exp_r = sb_queue.pop_front();
        checks++;
        if (bc != 32 || !sd) begin
            errors++;
            $display("[TB] FAIL %s_timing: got busy_cycles=%0d done=%b, want 32 and 1", name, bc, sd);
        end
        checks++;
        if (HI_output !== exp_r.hi || LO_output !== exp_r.lo) begin
            errors++;
            $display("[TB] FAIL %s_result: got HI=%h LO=%h, want HI=%h LO=%h",
                     name, HI_output, LO_output, exp_r.hi, exp_r.lo);
        end
    endtask

    task automatic test_multiply();
        test_scoreboard_op("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: got done=%b, want 0", done);
        end
        test_scoreboard_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    endtask

    task automatic test_divide();
        test_scoreboard_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        test_scoreboard_op("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        test_scoreboard_op("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        test_scoreboard_op("divu_by_zero", OP_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF});
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : $urandom;
            if (i == 2) b = {16'd0, b[15:0]};
            test_scoreboard_op($sformatf("random%0d", i), op, a, b, model(op, a, b));
        end
    endtask

    task automatic test_collision();
        result_t exp_r;
        bit sd;
        sb_queue.push_back({32'hFFFFFFFF, 32'hFFFFF830});
        start_execute       = 1'b1;
        mult_div_op_execute = OP_MULT;
        src_A_ALU_execute   = 32'd1000;
        src_B_ALU_execute   = 32'hFFFFFFFE;
        @(negedge clk);
        start_execute = 1'b0;
        repeat (4) @(negedge clk);
        start_execute       = 1'b1;
        mult_div_op_execute = OP_MTHI;
        src_A_ALU_execute   = 32'hAAAA;
        @(negedge clk);
        mult_div_op_execute = OP_DIVU;
        src_A_ALU_execute   = 32'd50;
        src_B_ALU_execute   = 32'd3;
        @(negedge clk);
        start_execute = 1'b0;
        sd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                sd = done;
                break;
            end
            @(negedge clk);
        end
        exp_r = sb_queue.pop_front();
        checks++;
        if (!sd || HI_output !== exp_r.hi || LO_output !== exp_r.lo) begin
            errors++;
            $display("[TB] FAIL collision_mult: got done=%b HI=%h LO=%h, want 1 HI=%h LO=%h",
                     sd, HI_output, LO_output, exp_r.hi, exp_r.lo);
        end
        start_execute       = 1'b1;
        mult_div_op_execute = OP_MTLO;
        src_A_ALU_execute   = 32'h55;
        @(negedge clk);
        start_execute = 1'b0;
        checks++;
        if (LO_output !== 32'h55 || HI_output !== exp_r.hi || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mtlo_in_done: got HI=%h LO=%h busy=%b done=%b, want HI=%h LO=00000055 busy=0 done=0",
                     HI_output, LO_output, busy, done, exp_r.hi);
        end
    endtask

    task automatic test_flush();
        bit saw_done;
        start_execute       = 1'b1;
        mult_div_op_execute = OP_MTHI;
        src_A_ALU_execute   = 32'h11;
        @(negedge clk);
        mult_div_op_execute = OP_MTLO;
        src_A_ALU_execute   = 32'h22;
        @(negedge clk);
        checks++;
        if (HI_output !== 32'h11 || LO_output !== 32'h22 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mthi_mtlo: got HI=%h LO=%h busy=%b, want 00000011 00000022 0",
                     HI_output, LO_output, busy);
        end
        mult_div_op_execute = OP_DIV;
        src_A_ALU_execute   = 32'd1000;
        src_B_ALU_execute   = 32'd9;
        @(negedge clk);
        start_execute = 1'b0;
        repeat (9) @(negedge clk);
        flush_execute = 1'b1;
        @(negedge clk);
        flush_execute = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_busy: got busy=%b done=%b, want 0 0", busy, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || HI_output !== 32'h11 || LO_output !== 32'h22) begin
            errors++;
            $display("[TB] FAIL flush_hold: got late_activity=%b HI=%h LO=%h, want 0 00000011 00000022",
                     saw_done, HI_output, LO_output);
        end
        start_execute       = 1'b1;
        flush_execute       = 1'b1;
        mult_div_op_execute = OP_MULT;
        src_A_ALU_execute   = 32'd5;
        src_B_ALU_execute   = 32'd6;
        @(negedge clk);
        mult_div_op_execute = OP_MTHI;
        src_A_ALU_execute   = 32'h99;
        @(negedge clk);
        start_execute = 1'b0;
        flush_execute = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI_output !== 32'h11 || LO_output !== 32'h22) begin
            errors++;
            $display("[TB] FAIL flush_with_start: got busy=%b HI=%h LO=%h, want 0 00000011 00000022",
                     busy, HI_output, LO_output);
        end
    endtask

    task automatic test_reset_mid_op();
        start_execute       = 1'b1;
        mult_div_op_execute = OP_MULT;
        src_A_ALU_execute   = 32'd12345;
        src_B_ALU_execute   = 32'd678;
        @(negedge clk);
        start_execute = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({HI_output, LO_output, busy, done} !== 66'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got HI=%h LO=%h busy=%b done=%b, want all zero",
                     HI_output, LO_output, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_scoreboard_op("multu_after_reset", OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15});
    endtask

    initial begin
        test_reset();
        test_multiply();
        @(negedge clk);
        test_divide();
        test_back_to_back();
        @(negedge clk);
        test_collision();
        @(negedge clk);
        test_flush();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit in the execute stage, directly downstream of the ALU operand mux. It consumes the forwarded operands `src_A_ALU_execute` / `src_B_ALU_execute` and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over multiple cycles. It holds the architectural HI/LO registers and exports `busy` to the hazard unit, which stalls MFHI/MFLO and further HI/LO operations.

## Interface
- No parameters; width fixed at 32 bits, iteration count fixed at 32.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_execute`  in  1  request from the execute stage; sampled only while idle.
- `mult_div_op_execute`  in  3  operation select:
  - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 000 and 111: no-op.
- `src_A_ALU_execute`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `src_B_ALU_execute`  in  32  rt operand: multiplier or divisor.
- `flush_execute`  in  1  abort in-flight operation; HI/LO unchanged.
- `HI_output`  out  32  architectural HI register.
- `LO_output`  out  32  architectural LO register.
- `busy`  out  1  registered; high while a MULT/DIV iteration is in flight.
- `done`  out  1  registered; one-cycle pulse after a MULT/DIV result is written to HI/LO.

## Operation
- States: IDLE, MUL, DIV. 5-bit iteration counter. `busy` = (state != IDLE).
- **IDLE, start with op 001–100:**
  - Latch operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops take operands as-is.
  - Latch the negate flags: product/quotient sign = A[31]^B[31]; remainder sign = A[31]. Flags are cleared for unsigned ops.
  - Clear the counter and go to MUL or DIV.
- **IDLE, start with op 101/110:** write `src_A` to HI/LO on that edge. Stay in IDLE; no `busy`, no `done`.
- **IDLE, start with op 000/111:** ignored.
- **Start while busy:** ignored. The hazard unit must stall.
- **MUL:**
  - Radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
  - Final cycle: 2's-complement-negate the 64-bit product if the negate flag is set, then write HI = [63:32], LO = [31:0].
- **DIV:**
  - Radix-2 restoring division, one quotient bit per cycle, 32 cycles.
  - Final cycle: LO = quotient and HI = remainder, each negated by its own flag.
- **Divide by zero:** no exception. Unsigned datapath result is quotient 0xFFFFFFFF, remainder = |dividend|, then the sign fixups apply.
  - DIVU x/0 gives LO=0xFFFFFFFF, HI=x.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO=0x80000000, HI=0 (natural wrap, no trap).
- **`flush_execute`:** any state returns to IDLE next edge. HI/LO not written, no `done`.
  - Flush has priority over start on the same edge: nothing is accepted.
- **Reset:** async assertion forces IDLE from any state. HI=0, LO=0, `busy`=0, `done`=0, counter=0, internal accumulators=0. Any in-flight operation is lost.

## Timing
- A MULT/DIV start accepted at rising edge E0 gives:
  - `busy`=1 from E0 through E32, i.e. 32 cycles.
  - HI/LO updated at E32.
  - `busy`=0 and `done`=1 for one cycle after E32.
- A back-to-back start in the `done` cycle is accepted; `busy` rises again at the next edge.
- MTHI/MTLO: HI/LO visible the cycle after the accepting edge. No latency to `busy`.
- HI/LO hold their previous values throughout an operation; there are no partial updates.
- Operands are sampled only at the accepting edge. Later changes to `src_A`/`src_B` have no effect.

## Test plan
- **Signed multiply:** reset, then MULT A=0xFFFFFFFD (−3), B=7.
  - Required: `busy` high exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB with a 1-cycle `done`.
  - Also: MULTU 0xFFFFFFFF×0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
- **Division:**
  - DIVU 100/7 gives LO=14, HI=2.
  - DIV −7/2 (0xFFFFFFF9, 2) gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero:** DIVU 0x1234/0 gives LO=0xFFFFFFFF, HI=0x1234, with `done` after 32 busy cycles.
- **Collision:** start a MULT, then at busy cycle 5 issue MTHI 0xAAAA and a DIVU.
  - Both are ignored; the MULT completes correctly.
  - An MTLO 0x55 issued in the `done` cycle gives LO=0x55 on the next cycle, HI unchanged.
- **Flush:** HI/LO preset via MTHI/MTLO to 0x11/0x22. Start a DIV, assert `flush_execute` at busy cycle 10.
  - Required: `busy`=0 next cycle, no `done`, HI/LO stay 0x11/0x22.
  - Flush together with start in IDLE: nothing is accepted.
- **Reset mid-operation:** deassert `reset_n` asynchronously mid-MULT.
  - Required: HI=LO=0 and `busy`=`done`=0 immediately.
  - After release, a fresh MULTU 3×5 gives LO=15, HI=0.
